// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, LSB-first byte
// with odd parity, stop bit, device ACK check and a per-edge watchdog.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       tx_active,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // state     | meaning
  // IDLE      | bus released, ready for a request
  // INHIBIT   | PS2Clk held low by the host
  // REQ       | start bit driven, waiting for the first device clock edge
  // SEND      | data bits, parity and stop bit shifted out on falling edges
  // ACK       | lines released, sampling device ACK on the next falling edge
  // WAIT_IDLE | waiting for the device to release both lines
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state;
  logic               clk_s1, clk_s2, clk_prev;
  logic               data_s1, data_s2;
  logic               clk_fall;
  logic               timeout_hit;
  logic [7:0]         data_q;
  logic               parity_q;
  logic [3:0]         bit_cnt;
  logic [INH_W-1:0]   inhibit_cnt;
  logic [TO_W-1:0]    timeout_cnt;

  // Pads idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_i;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_i;
      data_s2  <= data_s1;
    end
  end

  assign clk_fall    = clk_prev & ~clk_s2;
  assign timeout_hit = (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign tx_ready    = (state == IDLE);
  assign tx_active   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      bit_cnt     <= '0;
      inhibit_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid) begin
            data_q      <= tx_data;
            parity_q    <= ~^tx_data;
            inhibit_cnt <= INH_W'(INHIBIT_CYCLES - 1);
            ps2_clk_oe  <= 1'b1;
            state       <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inhibit_cnt == '0) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            timeout_cnt <= '0;
            bit_cnt     <= '0;
            state       <= REQ;
          end else begin
            inhibit_cnt <= inhibit_cnt - 1'b1;
          end
        end

        default: begin
          if (clk_fall)
            timeout_cnt <= '0;
          else
            timeout_cnt <= timeout_cnt + 1'b1;

          // A falling edge in the terminal cycle restarts the watchdog instead.
          if (timeout_hit && !clk_fall) begin
            tx_err      <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout_cnt <= '0;
            bit_cnt     <= '0;
            state       <= IDLE;
          end else begin
            case (state)
              REQ: begin
                if (clk_fall) begin
                  bit_cnt     <= 4'd1;
                  ps2_data_oe <= ~data_q[0];
                  state       <= SEND;
                end
              end

              SEND: begin
                if (clk_fall) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt < 4'd8) begin
                    ps2_data_oe <= ~data_q[bit_cnt[2:0]];
                  end else if (bit_cnt == 4'd8) begin
                    ps2_data_oe <= ~parity_q;
                  end else begin
                    ps2_data_oe <= 1'b0;
                    state       <= ACK;
                  end
                end
              end

              ACK: begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                if (clk_fall) begin
                  bit_cnt <= '0;
                  if (!data_s2) begin
                    state <= WAIT_IDLE;
                  end else begin
                    tx_err      <= 1'b1;
                    timeout_cnt <= '0;
                    state       <= IDLE;
                  end
                end
              end

              WAIT_IDLE: begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                if (clk_s2 && data_s2) begin
                  tx_done     <= 1'b1;
                  timeout_cnt <= '0;
                  state       <= IDLE;
                end
              end

              default: begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                state       <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a behavioural PS/2 device and a
// scoreboard of expected frames (byte, parity) popped when the device captures one.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, tx_active;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .tx_active  (tx_active),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_data_i (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  int   inh_cnt = 0;
  bit   inh_checked = 0;
  logic data_oe_prev = 1'b0;
  logic clk_oe_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Pulse counters and clock-inhibit length measured at the request-to-send moment.
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
    if (rst) begin
      inh_cnt = 0;
    end else begin
      if (ps2_data_oe && !data_oe_prev && clk_oe_prev) begin
        chk("inhibit_len", inh_cnt, INH);
        chk("clk_released_at_req", ps2_clk_oe, 1'b0);
        inh_checked = 1;
        inh_cnt = 0;
      end
      if (ps2_clk_oe) begin
        chk("data_released_in_inhibit", ps2_data_oe, 1'b0);
        inh_cnt++;
      end
    end
    data_oe_prev = ps2_data_oe;
    clk_oe_prev  = ps2_clk_oe;
  end

  task automatic send_req(input logic [7:0] b, input logic par, input bit expect_frame);
    int n = 0;
    exp_t e;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("active_after_accept", tx_active, 1'b1);
    chk("ready_low_busy", tx_ready, 1'b0);
    if (expect_frame) begin
      e.b = b;
      e.p = par;
      exp_q.push_back(e);
    end
  endtask

  // mode 0: clock and ACK, 1: clock without ACK, 2: reset after 5 bits, 3: never clock
  task automatic dev_frame(input int mode);
    int n = 0;
    logic [9:0] bits = '0;
    exp_t e;
    while (!(ps2_clk_line && !ps2_data_line) && n < INH + 100) begin
      @(negedge clk);
      n++;
    end
    chk("rts_seen", {31'd0, ps2_clk_line && !ps2_data_line}, 1);
    if (mode == 3) return;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      bits[i] = ps2_data_line;
      repeat (HALF / 2) @(negedge clk);
      if (mode == 2 && i == 4) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_data_oe", ps2_data_oe, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        rst = 1'b0;
        return;
      end
    end
    if (mode == 0) dev_data_low = 1'b1;
    repeat (4) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_data_low = 1'b0;
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("frame_data", bits[7:0], e.b);
      chk("frame_parity", bits[8], e.p);
      chk("frame_stop", bits[9], 1'b1);
    end
  endtask

  task automatic wait_result(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic good_send(input logic [7:0] b, input logic par, input bit busy_poke);
    int d0 = done_cnt;
    int e0 = err_cnt;
    inh_checked = 0;
    send_req(b, par, 1);
    if (busy_poke) begin
      repeat (10) @(negedge clk);
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    dev_frame(0);
    wait_result(d0, e0);
    chk("done_once", done_cnt - d0, 1);
    chk("no_err", err_cnt - e0, 0);
    chk("inhibit_measured", {31'd0, inh_checked}, 1);
    chk("ready_after_done", tx_ready, 1'b1);
    chk("idle_inactive", tx_active, 1'b0);
  endtask

  initial begin
    int d0, e0, cnt;
    repeat (5) @(negedge clk);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_active", tx_active, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_err", tx_err, 1'b0);
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    good_send(8'hF4, 1'b0, 0);
    good_send(8'h00, 1'b1, 0);
    good_send(8'hFF, 1'b1, 0);

    // Request while busy must be dropped, so no second frame may start.
    good_send(8'hF4, 1'b0, 1);
    repeat (INH + 50) @(negedge clk);
    chk("busy_req_dropped", ps2_clk_oe, 1'b0);
    chk("sb_empty", exp_q.size(), 0);

    // Device leaves data high on the ACK edge.
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'h55, 1'b1, 1);
    dev_frame(1);
    wait_result(d0, e0);
    chk("nack_err", err_cnt - e0, 1);
    chk("nack_no_done", done_cnt - d0, 0);
    chk("nack_ready", tx_ready, 1'b1);

    // No device clock after request-to-send.
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'hF4, 1'b0, 0);
    dev_frame(3);
    cnt = 0;
    while (!tx_err && cnt < TO + 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt, TO);
    chk("timeout_clk_oe", ps2_clk_oe, 1'b0);
    chk("timeout_data_oe", ps2_data_oe, 1'b0);
    repeat (5) @(negedge clk);
    chk("timeout_err_once", err_cnt - e0, 1);
    chk("timeout_no_done", done_cnt - d0, 0);

    // Reset part-way through the data bits, then a clean send.
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'hF4, 1'b0, 0);
    dev_frame(2);
    repeat (10) @(negedge clk);
    chk("rst_abort_no_done", done_cnt - d0, 0);
    chk("rst_abort_no_err", err_cnt - e0, 0);
    good_send(8'hFF, 1'b1, 0);

    chk("never_both_pulses", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
